// File: rtl/bcd2binary_seq_pkg.sv
// Shared definitions for the BCD/binary conversion paths.
// Holds the controller state encoding and the digit constants used by
// bcd2binary_seq and its per-digit adjust cell. binary2bcd can import the
// same package.
package bcd2binary_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_SHIFT = 3'd2,
    S_ADJ   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam logic [3:0] ADJ_THRESH = 4'd8;
  localparam logic [3:0] ADJ_SUB    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Per-digit correction for reverse double-dabble.
// After a right shift, a BCD nibble of 8 or more has picked up a binary
// weight of 8 where decimal needs 5, so 3 is taken off.
// Ports:
//   din  - nibble after the shift
//   dout - corrected nibble
module bcd_digit_adj
  import bcd2binary_seq_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // The subtract is only taken when din >= 8, so it cannot wrap.
  assign dout = (din >= ADJ_THRESH) ? (din - ADJ_SUB) : din;

endmodule

// File: rtl/bcd2binary_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
// The BCD digits and the growing binary result form one shift register;
// each iteration shifts it right by one and then corrects every digit that
// ended up at 8 or more. After BIN_W iterations the low part holds the
// binary value.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; captures bcd_in when it comes
// S_CHECK | reject captured digits greater than 9
// S_SHIFT | shift {bcd_r, bin_r} right by one, count the iteration
// S_ADJ   | correct all digits in parallel; finish after BIN_W shifts
// S_DONE  | one-cycle done pulse, then back to S_IDLE
//
// Ports:
//   clk     - system clock
//   clr_n   - asynchronous active-low reset
//   start   - conversion request, only looked at in S_IDLE
//   bcd_in  - packed BCD, digit 0 (ones) in bits [3:0]
//   busy    - conversion in progress
//   done    - one-cycle pulse, bin_out/err valid
//   err     - an accepted digit was above 9; held until the next result
//   bin_out - binary result, held until the next result
module bcd2binary_seq
  import bcd2binary_seq_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BIN_W-1:0]      bin_out
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIN_W);

  if ((2 ** BIN_W) <= ((10 ** DIGITS) - 1)) begin : g_width_check
    $error("bcd2binary_seq: BIN_W too small to hold the largest DIGITS-digit value");
  end

  state_t          state_q;
  state_t          state_d;
  logic [BW-1:0]   bcd_r;
  logic [BW-1:0]   bcd_adj;
  logic [BIN_W-1:0] bin_r;
  logic [CW-1:0]   cnt;
  logic            digit_bad;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (bcd_r[4*gi +: 4]),
      .dout (bcd_adj[4*gi +: 4])
    );
  end

  always_comb begin
    digit_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_r[4*i +: 4] > BCD_MAX) digit_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CHECK;
      S_CHECK: state_d = digit_bad ? S_DONE : S_SHIFT;
      S_SHIFT: state_d = S_ADJ;
      S_ADJ:   state_d = (cnt == CNT_LAST) ? S_DONE : S_SHIFT;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Flags are registered from the next state so they line up exactly with
  // the state register without a decode after the flops.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      bin_out <= '0;
      bcd_r   <= '0;
      bin_r   <= '0;
      cnt     <= '0;
    end else begin
      busy <= (state_d == S_CHECK) || (state_d == S_SHIFT) || (state_d == S_ADJ);
      done <= (state_d == S_DONE);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            bcd_r <= bcd_in;
            bin_r <= '0;
            cnt   <= '0;
          end
        end
        S_CHECK: begin
          if (digit_bad) begin
            err     <= 1'b1;
            bin_out <= '0;
          end
        end
        S_SHIFT: begin
          bcd_r <= bcd_r >> 1;
          bin_r <= {bcd_r[0], bin_r[BIN_W-1:1]};
          cnt   <= cnt + 1'b1;
        end
        S_ADJ: begin
          // The correction after the final shift is harmless: only bin_r
          // is used from here on.
          bcd_r <= bcd_adj;
          if (cnt == CNT_LAST) begin
            bin_out <= bin_r;
            err     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2binary_seq.sv
module tb_bcd2binary_seq;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] bcd_in = 8'h00;
  logic       busy;
  logic       done;
  logic       err;
  logic [6:0] bin_out;

  int errors = 0;
  int checks = 0;

  logic [6:0] exp_bin_q = 7'd0;
  logic       exp_err_q = 1'b0;

  bcd2binary_seq #(.DIGITS(2), .BIN_W(7)) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .bin_out (bin_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One conversion from IDLE: start seen at edge 0, then wait for done.
  task automatic run_conv(input logic [7:0] v, input logic e_err,
                          input logic [6:0] e_bin, input int e_lat,
                          input string tag);
    int  n;
    bit  held;
    bcd_in = v;
    start  = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ".busy_after_accept"}, int'(busy), 1);
    n = 0;
    held = 1'b1;
    while (n < 40) begin
      tick();
      n++;
      if (done) break;
      if (bin_out !== exp_bin_q || err !== exp_err_q) held = 1'b0;
    end
    chk({tag, ".latency"}, n, e_lat);
    chk({tag, ".held_before_done"}, int'(held), 1);
    chk({tag, ".err"}, int'(err), int'(e_err));
    chk({tag, ".bin"}, int'(bin_out), int'(e_bin));
    chk({tag, ".busy_at_done"}, int'(busy), 0);
    tick();
    chk({tag, ".done_one_cycle"}, int'(done), 0);
    exp_bin_q = e_bin;
    exp_err_q = e_err;
  endtask

  initial begin
    int n;
    int dones;
    int first_e;
    int last_e;
    int gap_ok;
    bit ok63;

    // reset values
    #1;
    chk("reset.busy", int'(busy), 0);
    chk("reset.done", int'(done), 0);
    chk("reset.err", int'(err), 0);
    chk("reset.bin", int'(bin_out), 0);
    tick();
    clr_n = 1'b1;
    tick();
    chk("idle.busy", int'(busy), 0);

    // 1: largest valid value
    run_conv(8'h99, 1'b0, 7'd99, 15, "t1_99");

    // 2: assorted values
    run_conv(8'h42, 1'b0, 7'd42, 15, "t2_42");
    run_conv(8'h00, 1'b0, 7'd0,  15, "t2_00");
    run_conv(8'h10, 1'b0, 7'd10, 15, "t2_10");

    // 3: invalid digit, then recovery
    run_conv(8'h3A, 1'b1, 7'd0, 1, "t3_3A");
    run_conv(8'hF9, 1'b1, 7'd0, 1, "t3_F9");
    run_conv(8'h05, 1'b0, 7'd5, 15, "t3_05");

    // 4: start and bcd_in disturbed during a conversion
    bcd_in = 8'h27;
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    start  = 1'b1;
    bcd_in = 8'h11;
    tick(); tick();
    start = 1'b0;
    n = 4;
    while (n < 40 && !done) begin
      tick();
      n++;
    end
    chk("t4.latency", n, 15);
    chk("t4.bin", int'(bin_out), 27);
    chk("t4.err", int'(err), 0);
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) dones++;
    end
    chk("t4.single_done", dones, 0);
    exp_bin_q = 7'd27;
    exp_err_q = 1'b0;

    // 5: reset in the middle of a conversion
    bcd_in = 8'h58;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2;
    clr_n = 1'b0;
    #1;
    chk("t5.busy_reset", int'(busy), 0);
    chk("t5.bin_reset", int'(bin_out), 0);
    chk("t5.err_reset", int'(err), 0);
    chk("t5.done_reset", int'(done), 0);
    tick();
    clr_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done || busy) dones++;
    end
    chk("t5.quiet_after_release", dones, 0);
    exp_bin_q = 7'd0;
    exp_err_q = 1'b0;
    run_conv(8'h58, 1'b0, 7'd58, 15, "t5_58");

    // 6: start held high, back-to-back conversions
    bcd_in = 8'h63;
    start  = 1'b1;
    dones   = 0;
    first_e = -1;
    last_e  = -1;
    gap_ok  = 1;
    ok63    = 1'b1;
    for (int e = 0; e < 80 && dones < 3; e++) begin
      tick();
      if (done) begin
        if (dones == 0) first_e = e;
        else if (e - last_e != 17) gap_ok = 0;
        if (bin_out !== 7'd63 || err !== 1'b0) ok63 = 1'b0;
        last_e = e;
        dones++;
      end
    end
    start = 1'b0;
    chk("t6.done_count", dones, 3);
    chk("t6.first_done_edge", first_e, 15);
    chk("t6.gap_17", gap_ok, 1);
    chk("t6.value_63", int'(ok63), 1);
    tick(); tick();
    exp_bin_q = 7'd63;
    exp_err_q = 1'b0;

    // exhaustive sweep of valid inputs
    for (int t = 0; t < 10; t++) begin
      for (int o = 0; o < 10; o++) begin
        logic [7:0] v;
        logic [6:0] e;
        v = {4'(t), 4'(o)};
        e = 7'(t * 10 + o);
        run_conv(v, 1'b0, e, 15, "sweep");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
